regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Purpose : bundles the two writeback requesters (ALU, MEM) and the
//           register-file write port seen by regfile_wb_arbiter.
// Signals :
//   alu_Valid/alu_Reg/alu_Data  ALU writeback request (requester -> arbiter)
//   alu_Ready                   ALU request accepted this cycle (arbiter -> requester)
//   mem_Valid/mem_Reg/mem_Data  load writeback request (requester -> arbiter)
//   mem_Ready                   MEM request accepted this cycle (arbiter -> requester)
//   reg_Write/write_Reg/write_Data  registered register-file write port
//   pend_Mask                   one-hot of write_Reg while reg_Write=1
//   write_Count                 running count of committed writes
// Modports: master = requester/regfile side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
  logic        alu_Valid;
  logic [4:0]  alu_Reg;
  logic [63:0] alu_Data;
  logic        alu_Ready;
  logic        mem_Valid;
  logic [4:0]  mem_Reg;
  logic [63:0] mem_Data;
  logic        mem_Ready;
  logic        reg_Write;
  logic [4:0]  write_Reg;
  logic [63:0] write_Data;
  logic [31:0] pend_Mask;
  logic [15:0] write_Count;

  modport master (
    output alu_Valid, alu_Reg, alu_Data,
    input  alu_Ready,
    output mem_Valid, mem_Reg, mem_Data,
    input  mem_Ready,
    input  reg_Write, write_Reg, write_Data, pend_Mask, write_Count
  );

  modport slave (
    input  alu_Valid, alu_Reg, alu_Data,
    output alu_Ready,
    input  mem_Valid, mem_Reg, mem_Data,
    output mem_Ready,
    output reg_Write, write_Reg, write_Data, pend_Mask, write_Count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Purpose : arbitrates ALU and MEM writeback requests onto a single
//           register-file write port. ALU normally wins; a MEM requester
//           stalled for STARVE_MAX consecutive cycles gets priority until it
//           is accepted. Destination 31 (XZR) is accepted and dropped.
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   wb     regfile_wb_arbiter_if.slave (requests, readies, write port)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_arbiter_if.slave    wb
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    ALU_PRI = 1'b0,
    MEM_PRI = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [63:0] write_data_q, write_data_d;
  logic [15:0] write_count_q, write_count_d;

  logic alu_xzr_s, mem_xzr_s;
  logic alu_real_s, mem_real_s;
  logic alu_grant_s, mem_grant_s;
  logic alu_ready_s, mem_ready_s;

  // Request classification and priority arbitration between real writes.
  always_comb begin
    alu_xzr_s   = wb.alu_Valid && (wb.alu_Reg == 5'd31);
    mem_xzr_s   = wb.mem_Valid && (wb.mem_Reg == 5'd31);
    alu_real_s  = wb.alu_Valid && (wb.alu_Reg != 5'd31);
    mem_real_s  = wb.mem_Valid && (wb.mem_Reg != 5'd31);
    // Only two real writes compete for the port; XZR requests never conflict.
    alu_grant_s = alu_real_s && (!mem_real_s || (state_q == ALU_PRI));
    mem_grant_s = mem_real_s && (!alu_real_s || (state_q == MEM_PRI));
    // Nothing is accepted while reset is held low.
    alu_ready_s = reset && (alu_xzr_s || alu_grant_s);
    mem_ready_s = reset && (mem_xzr_s || mem_grant_s);
  end

  // Next-state for write port, commit counter, starve counter and FSM.
  always_comb begin
    reg_write_d   = 1'b0;
    write_reg_d   = write_reg_q;
    write_data_d  = write_data_q;
    write_count_d = write_count_q;
    starve_d      = starve_q;
    state_d       = state_q;

    if (alu_ready_s && alu_real_s) begin
      reg_write_d  = 1'b1;
      write_reg_d  = wb.alu_Reg;
      write_data_d = wb.alu_Data;
    end else if (mem_ready_s && mem_real_s) begin
      reg_write_d  = 1'b1;
      write_reg_d  = wb.mem_Reg;
      write_data_d = wb.mem_Data;
    end else begin
      reg_write_d  = 1'b0;
    end

    if (reg_write_d) begin
      write_count_d = write_count_q + 16'd1;
    end else begin
      write_count_d = write_count_q;
    end

    // Any MEM acceptance (including an XZR discard) ends the stall run.
    if (mem_ready_s) begin
      starve_d = 4'd0;
    end else if (wb.mem_Valid && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end

    case (state_q)
      ALU_PRI: begin
        if (starve_d == STARVE_LIM) begin
          state_d = MEM_PRI;
        end else begin
          state_d = ALU_PRI;
        end
      end
      MEM_PRI: begin
        if (mem_ready_s) begin
          state_d = ALU_PRI;
        end else begin
          state_d = MEM_PRI;
        end
      end
      default: begin
        state_d = ALU_PRI;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ALU_PRI;
      starve_q      <= 4'd0;
      reg_write_q   <= 1'b0;
      write_reg_q   <= 5'd0;
      write_data_q  <= 64'd0;
      write_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      reg_write_q   <= reg_write_d;
      write_reg_q   <= write_reg_d;
      write_data_q  <= write_data_d;
      write_count_q <= write_count_d;
    end
  end

  assign wb.alu_Ready   = alu_ready_s;
  assign wb.mem_Ready   = mem_ready_s;
  assign wb.reg_Write   = reg_write_q;
  assign wb.write_Reg   = write_reg_q;
  assign wb.write_Data  = write_data_q;
  assign wb.write_Count = write_count_q;
  // Decoded from the registered write port so it tracks reg_Write exactly.
  assign wb.pend_Mask   = reg_write_q ? (32'd1 << write_reg_q) : 32'd0;

endmodule
